pipeline_hazard_ctrl: RTL and testbench

Parametrised hazard controller for the in-order RISC-V integer pipeline, sitting beside the ID stage. Tracks the destination registers of in-flight instructions in an internal per-stage shadow pipeline. Produces per-operand forwarding selects, load-use and multi-cycle-unit stalls, and branch flushes. Adds a register scoreboard for the long-latency multiply/divide unit, which the single-cycle-forwarding-only design lacked.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/pipeline_hazard_ctrl_if.sv | 52 +++++
 rtl/hazard_scoreboard.sv | 61 ++++++
 rtl/pipeline_hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Shadow-entry layout and forwarding-select encodings live here.
package hazard_pkg;

  localparam int RA_W_DEF = 5;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef struct packed {
    logic                valid;
    logic [RA_W_DEF-1:0] rd;
    logic                wr;
    logic                is_load;
  } shadow_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ID-side hazard bundle: decode info in, forwarding/stall/flush out.
// master = pipeline side, slave = hazard controller.
interface pipeline_hazard_ctrl_if
  import hazard_pkg::*;
#(
  parameter int RA_W  = RA_W_DEF,
  parameter int SEL_W = 2
);

  logic            id_valid;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic            id_rs1_used;
  logic            id_rs2_used;
  logic [RA_W-1:0] id_rd;
  logic            id_wr;
  logic            id_is_load;
  logic            id_is_mc;
  logic            took_branch;
  logic            mc_done;
  logic [RA_W-1:0] mc_done_rd;

  logic [SEL_W-1:0] fwd_sel_a;
  logic [SEL_W-1:0] fwd_sel_b;
  logic             stall_id;
  logic             flush_if;
  logic             flush_id;
  logic             mc_full;

  modport master (
    output id_valid, id_rs1, id_rs2,
    output id_rs1_used, id_rs2_used,
    output id_rd, id_wr, id_is_load,
    output id_is_mc, took_branch,
    output mc_done, mc_done_rd,
    input  fwd_sel_a, fwd_sel_b,
    input  stall_id, flush_if, flush_id,
    input  mc_full
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2,
    input  id_rs1_used, id_rs2_used,
    input  id_rd, id_wr, id_is_load,
    input  id_is_mc, took_branch,
    input  mc_done, mc_done_rd,
    output fwd_sel_a, fwd_sel_b,
    output stall_id, flush_if, flush_id,
    output mc_full
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// Busy-bit scoreboard and outstanding-op counter for the
// multi-cycle (mul/div) unit.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int RA_W   = RA_W_DEF,
  parameter int MC_MAX = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue,
  input  logic [RA_W-1:0] issue_rd,
  input  logic            done,
  input  logic [RA_W-1:0] done_rd,
  input  logic [RA_W-1:0] rs1,
  input  logic            rs1_used,
  input  logic [RA_W-1:0] rs2,
  input  logic            rs2_used,
  input  logic [RA_W-1:0] rd,
  input  logic            wr,
  input  logic            is_mc,
  output logic            mc_haz,
  output logic            mc_full
);

  localparam int NREG  = 1 << RA_W;
  localparam int CNT_W = $clog2(MC_MAX + 1);

  logic [NREG-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    busy_d = busy_q;
    if (done)  busy_d[done_rd]  = 1'b0;
    if (issue) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
    cnt_d = cnt_q;
    case ({issue, done})
      2'b10: if (cnt_q != CNT_W'(MC_MAX)) cnt_d = cnt_q + 1'b1;
      2'b01: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign mc_full = (cnt_q == CNT_W'(MC_MAX));
  assign mc_haz  = (busy_q[rs1] & rs1_used)
                 | (busy_q[rs2] & rs2_used)
                 | (busy_q[rd] & wr)
                 | (is_mc & mc_full);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ID-side hazard controller: forwarding, load-use/MC stalls, flushes.
// Optional HAZARD_STATS_EN adds stall/flush/mc-stall counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter  int DEPTH    = 3,
  parameter  int RA_W     = RA_W_DEF,
  parameter  int LOAD_GAP = 1,
  parameter  int MC_MAX   = 2,
  localparam int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        reset,
`ifdef HAZARD_STATS_EN
  output logic [31:0] stat_stalls,
  output logic [31:0] stat_flushes,
  output logic [31:0] stat_mc_stalls,
`endif
  pipeline_hazard_ctrl_if.slave hz
);

  shadow_t shadow_q [DEPTH];
  shadow_t shadow_d [DEPTH];

  logic             lu_a, lu_b;
  logic [SEL_W-1:0] sel_a, sel_b;
  logic             mc_haz, stall, accept, issue;
  logic [RA_W-1:0]  issue_rd;

  // Youngest entry wins, so scan oldest-first and let later hits override.
  function automatic logic [SEL_W:0] pick(
    input logic [RA_W-1:0] rs,
    input logic            used
  );
    logic [SEL_W-1:0] sel = SEL_W'(FWD_RF);
    logic             lu  = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (shadow_q[k].valid && shadow_q[k].wr &&
          shadow_q[k].rd == rs && rs != '0 && used) begin
        sel = SEL_W'(k + 1);
        lu  = shadow_q[k].is_load && (k < LOAD_GAP);
      end
    end
    if (lu) sel = SEL_W'(FWD_RF);
    return {lu, sel};
  endfunction

  assign {lu_a, sel_a} = pick(hz.id_rs1, hz.id_rs1_used);
  assign {lu_b, sel_b} = pick(hz.id_rs2, hz.id_rs2_used);

  assign stall    = hz.id_valid & ~hz.took_branch
                  & (lu_a | lu_b | mc_haz);
  assign accept   = hz.id_valid & ~stall & ~hz.took_branch;
  assign issue    = accept & hz.id_is_mc;
  assign issue_rd = hz.id_wr ? hz.id_rd : '0;

  assign hz.fwd_sel_a = sel_a;
  assign hz.fwd_sel_b = sel_b;
  assign hz.stall_id  = stall;
  assign hz.flush_if  = hz.took_branch;
  assign hz.flush_id  = hz.took_branch;

  always_comb begin
    shadow_d[0] = '0;
    if (accept) begin
      shadow_d[0].valid   = 1'b1;
      shadow_d[0].rd      = hz.id_rd;
      shadow_d[0].wr      = hz.id_wr & ~hz.id_is_mc;
      shadow_d[0].is_load = hz.id_is_load;
    end
    for (int k = 1; k < DEPTH; k++) shadow_d[k] = shadow_q[k-1];
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++) begin
      if (reset) shadow_q[k] <= '0;
      else       shadow_q[k] <= shadow_d[k];
    end
  end

  hazard_scoreboard #(
    .RA_W   (RA_W),
    .MC_MAX (MC_MAX)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .issue    (issue),
    .issue_rd (issue_rd),
    .done     (hz.mc_done),
    .done_rd  (hz.mc_done_rd),
    .rs1      (hz.id_rs1),
    .rs1_used (hz.id_rs1_used),
    .rs2      (hz.id_rs2),
    .rs2_used (hz.id_rs2_used),
    .rd       (hz.id_rd),
    .wr       (hz.id_wr),
    .is_mc    (hz.id_is_mc),
    .mc_haz   (mc_haz),
    .mc_full  (hz.mc_full)
  );

`ifdef HAZARD_STATS_EN
  logic [31:0] st_stall_q, st_stall_d;
  logic [31:0] st_flush_q, st_flush_d;
  logic [31:0] st_mc_q, st_mc_d;

  always_comb begin
    st_stall_d = st_stall_q + {31'd0, stall};
    st_flush_d = st_flush_q + {31'd0, hz.took_branch};
    st_mc_d    = st_mc_q + {31'd0, stall & mc_haz};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_stall_q <= '0;
      st_flush_q <= '0;
      st_mc_q    <= '0;
    end else begin
      st_stall_q <= st_stall_d;
      st_flush_q <= st_flush_d;
      st_mc_q    <= st_mc_d;
    end
  end

  assign stat_stalls    = st_stall_q;
  assign stat_flushes   = st_flush_q;
  assign stat_mc_stalls = st_mc_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scenario bench for pipeline_hazard_ctrl: per-cycle stimulus rows,
// expected outputs queued at drive time and popped at the negedge.
module tb_pipeline_hazard_ctrl;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.RA_W(5), .SEL_W(2)) hz ();

`ifdef HAZARD_STATS_EN
  logic [31:0] stat_stalls, stat_flushes, stat_mc_stalls;
`endif

  pipeline_hazard_ctrl dut (
    .clk            (clk),
    .reset          (reset),
`ifdef HAZARD_STATS_EN
    .stat_stalls    (stat_stalls),
    .stat_flushes   (stat_flushes),
    .stat_mc_stalls (stat_mc_stalls),
`endif
    .hz             (hz)
  );

  typedef struct {
    logic       rst, v, u1, u2, wr, ld, mc, br, dn;
    logic [4:0] rs1, rs2, rd, dn_rd;
    logic [7:0] exp;
  } row_t;

  logic [7:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [7:0] e(int fa, int fb, int st, int br,
                                   int full);
    return {2'(fa), 2'(fb), st != 0, br != 0, br != 0, full != 0};
  endfunction

  function automatic row_t r(int rst, int v, int rs1, int u1,
                             int rs2, int u2, int rd, int wr,
                             int ld, int mc, int br, int dn,
                             int dn_rd, logic [7:0] exp);
    row_t x;
    x.rst = rst != 0; x.v  = v != 0;
    x.rs1 = 5'(rs1);  x.u1 = u1 != 0;
    x.rs2 = 5'(rs2);  x.u2 = u2 != 0;
    x.rd  = 5'(rd);   x.wr = wr != 0;
    x.ld  = ld != 0;  x.mc = mc != 0;
    x.br  = br != 0;  x.dn = dn != 0;
    x.dn_rd = 5'(dn_rd);
    x.exp = exp;
    return x;
  endfunction

  function automatic row_t idle(int dn, int dn_rd, logic [7:0] exp);
    return r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, dn, dn_rd, exp);
  endfunction

  function automatic logic [7:0] obs();
    return {hz.fwd_sel_a, hz.fwd_sel_b, hz.stall_id,
            hz.flush_if, hz.flush_id, hz.mc_full};
  endfunction

  task automatic apply(input row_t x);
    reset          = x.rst;
    hz.id_valid    = x.v;
    hz.id_rs1      = x.rs1;
    hz.id_rs1_used = x.u1;
    hz.id_rs2      = x.rs2;
    hz.id_rs2_used = x.u2;
    hz.id_rd       = x.rd;
    hz.id_wr       = x.wr;
    hz.id_is_load  = x.ld;
    hz.id_is_mc    = x.mc;
    hz.took_branch = x.br;
    hz.mc_done     = x.dn;
    hz.mc_done_rd  = x.dn_rd;
    exp_q.push_back(x.exp);
  endtask

  task automatic test_reset();
    row_t rows[$];
    logic [7:0] got, want;
    rows.push_back(r(0, 1, 5, 1, 7, 1, 6, 1, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0)));
    rows.push_back(idle(0, 0, e(0, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL reset[%0d] got=%b want=%b", i, got, want);
      end
`ifdef HAZARD_STATS_EN
      total++;
      if ({stat_stalls, stat_flushes, stat_mc_stalls} !== 96'd0) begin
        bad++;
        $display("FAIL reset_stats got=%0d/%0d/%0d want=0/0/0",
                 stat_stalls, stat_flushes, stat_mc_stalls);
      end
`endif
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fwd_alu();
    row_t rows[$];
    logic [7:0] got, want;
    rows.push_back(r(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0)));
    rows.push_back(r(0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, e(1, 0, 0, 0, 0)));
    rows.push_back(r(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(2, 0, 0, 0, 0)));
    rows.push_back(r(0, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, e(3, 2, 0, 0, 0)));
    repeat (3) rows.push_back(idle(0, 0, e(0, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL fwd_alu[%0d] got=%b want=%b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    row_t rows[$];
    logic [7:0] got, want;
    rows.push_back(r(0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, e(0, 0, 0, 0, 0)));
    rows.push_back(r(0, 1, 0, 0, 7, 1, 8, 1, 0, 0, 0, 0, 0, e(0, 0, 1, 0, 0)));
    rows.push_back(r(0, 1, 0, 0, 7, 1, 8, 1, 0, 0, 0, 0, 0, e(0, 2, 0, 0, 0)));
    repeat (3) rows.push_back(idle(0, 0, e(0, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL load_use[%0d] got=%b want=%b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_youngest();
    row_t rows[$];
    logic [7:0] got, want;
    rows.push_back(r(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0)));
    rows.push_back(r(0, 1, 0, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0)));
    rows.push_back(r(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0)));
    rows.push_back(r(0, 1, 3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, e(1, 0, 0, 0, 0)));
    repeat (3) rows.push_back(idle(0, 0, e(0, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL youngest[%0d] got=%b want=%b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mc_dep();
    row_t rows[$];
    logic [7:0] got, want;
    rows.push_back(r(0, 1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0, 0, e(0, 0, 0, 0, 0)));
    rows.push_back(r(0, 1, 9, 1, 0, 0, 10, 1, 0, 0, 0, 0, 0, e(0, 0, 1, 0, 0)));
    rows.push_back(r(0, 1, 9, 1, 0, 0, 10, 1, 0, 0, 0, 0, 0, e(0, 0, 1, 0, 0)));
    rows.push_back(r(0, 1, 9, 1, 0, 0, 10, 1, 0, 0, 0, 1, 9, e(0, 0, 1, 0, 0)));
    rows.push_back(r(0, 1, 9, 1, 0, 0, 10, 1, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0)));
    repeat (3) rows.push_back(idle(0, 0, e(0, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL mc_dep[%0d] got=%b want=%b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mc_full_branch();
    row_t rows[$];
    logic [7:0] got, want;
    rows.push_back(r(0, 1, 0, 0, 0, 0, 11, 1, 0, 1, 0, 0, 0, e(0, 0, 0, 0, 0)));
    rows.push_back(r(0, 1, 0, 0, 0, 0, 12, 1, 0, 1, 0, 0, 0, e(0, 0, 0, 0, 0)));
    rows.push_back(idle(0, 0, e(0, 0, 0, 0, 1)));
    rows.push_back(r(0, 1, 0, 0, 0, 0, 13, 1, 0, 1, 0, 0, 0, e(0, 0, 1, 0, 1)));
    rows.push_back(r(0, 1, 0, 0, 0, 0, 13, 1, 0, 1, 1, 0, 0, e(0, 0, 0, 1, 1)));
    rows.push_back(idle(1, 11, e(0, 0, 0, 0, 1)));
    rows.push_back(r(0, 1, 0, 0, 0, 0, 14, 1, 0, 1, 0, 1, 12, e(0, 0, 0, 0, 0)));
    rows.push_back(idle(0, 0, e(0, 0, 0, 0, 0)));
    rows.push_back(idle(1, 14, e(0, 0, 0, 0, 0)));
    rows.push_back(idle(0, 0, e(0, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL mc_full_br[%0d] got=%b want=%b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    row_t rows[$];
    logic [7:0] got, want;
    rows.push_back(r(0, 1, 0, 0, 0, 0, 15, 1, 0, 1, 0, 0, 0, e(0, 0, 0, 0, 0)));
    rows.push_back(r(0, 1, 0, 0, 0, 0, 16, 1, 1, 0, 0, 0, 0, e(0, 0, 0, 0, 0)));
    rows.push_back(r(1, 1, 16, 1, 15, 1, 17, 1, 0, 0, 0, 0, 0, e(0, 0, 1, 0, 0)));
    rows.push_back(r(0, 1, 16, 1, 15, 1, 17, 1, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0)));
    rows.push_back(idle(0, 0, e(0, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL reset_mid[%0d] got=%b want=%b", i, got, want);
      end
`ifdef HAZARD_STATS_EN
      if (i == 3) begin
        total++;
        if ({stat_stalls, stat_flushes, stat_mc_stalls} !== 96'd0) begin
          bad++;
          $display("FAIL reset_mid_stats got=%0d/%0d/%0d want=0/0/0",
                   stat_stalls, stat_flushes, stat_mc_stalls);
        end
      end
`endif
      @(posedge clk); #1;
    end
  endtask

  initial begin
    apply(idle(0, 0, 8'd0));
    void'(exp_q.pop_front());
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fwd_alu();
    test_load_use();
    test_youngest();
    test_mc_dep();
    test_mc_full_branch();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_left got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
